rx_block_assembler: RTL and testbench



---
 rtl/rx_block_assembler.sv | 161 ++++++++++++++++
 tb/tb_rx_block_assembler.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/rx_block_assembler.sv
// rx_block_assembler: packs 32-bit write words into 128-bit key/video blocks.
// A fill buffer collects words. A hold register presents one complete block
// to the AES controller. A block that completes while the hold register is
// busy waits, complete, in the fill buffer until the held block is consumed.
module rx_block_assembler (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         word_valid,
  input  logic [31:0]  word_data,
  input  logic         word_type,
  output logic         word_ready,
  input  logic         consume,
  input  logic         flush,
  output logic         data_received,
  output logic         data_type,
  output logic [127:0] block_out,
  output logic         type_error,
  output logic [2:0]   fill_count
);

  // Fill side state
  logic [127:0] fill_buf_q,   fill_buf_d;
  logic [1:0]   idx_q,        idx_d;
  logic         fill_type_q,  fill_type_d;
  logic         fill_full_q,  fill_full_d;

  // Hold side state
  logic [127:0] hold_q,       hold_d;
  logic         hold_valid_q, hold_valid_d;
  logic         hold_type_q,  hold_type_d;

  logic         type_error_q, type_error_d;

  // Combinational helpers
  logic         hold_free_s;
  logic         accept_s;
  logic         load_s;

  // Places a word into its MSB-first slot of a 128-bit block.
  function automatic logic [127:0] put_word(input logic [127:0] blk,
                                            input logic [1:0]   idx,
                                            input logic [31:0]  w);
    logic [127:0] r;
    r = blk;
    case (idx)
      2'd0:    r[127:96] = w;
      2'd1:    r[95:64]  = w;
      2'd2:    r[63:32]  = w;
      2'd3:    r[31:0]   = w;
      default: r = blk;
    endcase
    return r;
  endfunction

  // Next-state logic: flush, fill-buffer transfer, word accept, consume.
  always_comb begin
    fill_buf_d   = fill_buf_q;
    idx_d        = idx_q;
    fill_type_d  = fill_type_q;
    fill_full_d  = fill_full_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    hold_type_d  = hold_type_q;
    type_error_d = 1'b0;
    load_s       = 1'b0;

    hold_free_s  = !hold_valid_q || consume;
    accept_s     = word_valid && !fill_full_q;

    if (flush) begin
      // Held block contents and type are kept; only validity is dropped.
      idx_d        = 2'd0;
      fill_full_d  = 1'b0;
      hold_valid_d = 1'b0;
    end else begin
      if (fill_full_q) begin
        // Pending complete block moves to hold as soon as hold frees up.
        if (hold_free_s) begin
          hold_d       = fill_buf_q;
          hold_type_d  = fill_type_q;
          hold_valid_d = 1'b1;
          fill_full_d  = 1'b0;
          idx_d        = 2'd0;
          load_s       = 1'b1;
        end else begin
          fill_full_d  = 1'b1;
        end
      end else if (accept_s) begin
        if ((idx_q != 2'd0) && (word_type != fill_type_q)) begin
          // Type changed mid-block: restart the block with this word.
          fill_buf_d   = put_word(fill_buf_q, 2'd0, word_data);
          fill_type_d  = word_type;
          idx_d        = 2'd1;
          type_error_d = 1'b1;
        end else begin
          fill_buf_d = put_word(fill_buf_q, idx_q, word_data);
          if (idx_q == 2'd0) begin
            fill_type_d = word_type;
          end else begin
            fill_type_d = fill_type_q;
          end
          if (idx_q == 2'd3) begin
            idx_d = 2'd0;
            if (hold_free_s) begin
              // Fourth word goes straight through to hold at this edge.
              hold_d       = fill_buf_d;
              hold_type_d  = fill_type_q;
              hold_valid_d = 1'b1;
              load_s       = 1'b1;
            end else begin
              fill_full_d  = 1'b1;
            end
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end else begin
        idx_d = idx_q;
      end

      // Consume without a same-cycle reload empties the hold register.
      if (consume && !load_s) begin
        hold_valid_d = 1'b0;
      end else begin
        hold_valid_d = hold_valid_d;
      end
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      fill_buf_q   <= 128'd0;
      idx_q        <= 2'd0;
      fill_type_q  <= 1'b0;
      fill_full_q  <= 1'b0;
      hold_q       <= 128'd0;
      hold_valid_q <= 1'b0;
      hold_type_q  <= 1'b0;
      type_error_q <= 1'b0;
    end else begin
      fill_buf_q   <= fill_buf_d;
      idx_q        <= idx_d;
      fill_type_q  <= fill_type_d;
      fill_full_q  <= fill_full_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      hold_type_q  <= hold_type_d;
      type_error_q <= type_error_d;
    end
  end

  // Outputs are driven from registered state only.
  assign word_ready    = !fill_full_q;
  assign data_received = hold_valid_q;
  assign data_type     = hold_type_q;
  assign block_out     = hold_q;
  assign type_error    = type_error_q;
  assign fill_count    = fill_full_q ? 3'd4 : {1'b0, idx_q};

endmodule

// File: tb/tb_rx_block_assembler.sv
// Self-checking bench for rx_block_assembler: directed test-plan steps
// followed by randomized traffic, compared against a queue-based model.
module tb_rx_block_assembler;

  logic         clk = 1'b0;
  logic         n_rst = 1'b0;
  logic         word_valid = 1'b0;
  logic [31:0]  word_data = 32'd0;
  logic         word_type = 1'b0;
  logic         word_ready;
  logic         consume = 1'b0;
  logic         flush = 1'b0;
  logic         data_received;
  logic         data_type;
  logic [127:0] block_out;
  logic         type_error;
  logic [2:0]   fill_count;

  int errors = 0;
  int checks = 0;

  // Reference model: words waiting in the fill buffer, and the held block.
  logic [31:0]  m_fill[$];
  logic         m_ftype = 1'b0;
  logic         m_hvalid = 1'b0;
  logic         m_htype = 1'b0;
  logic [127:0] m_hblock = 128'd0;
  logic         m_terr = 1'b0;

  rx_block_assembler dut (
    .clk(clk), .n_rst(n_rst), .word_valid(word_valid), .word_data(word_data),
    .word_type(word_type), .word_ready(word_ready), .consume(consume),
    .flush(flush), .data_received(data_received), .data_type(data_type),
    .block_out(block_out), .type_error(type_error), .fill_count(fill_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("data_received", {127'd0, data_received}, {127'd0, m_hvalid});
    chk("data_type",     {127'd0, data_type},     {127'd0, m_htype});
    chk("block_out",     block_out,               m_hblock);
    chk("type_error",    {127'd0, type_error},    {127'd0, m_terr});
    chk("fill_count",    {125'd0, fill_count},    128'(m_fill.size()));
    chk("word_ready",    {127'd0, word_ready},    {127'd0, (m_fill.size() < 4)});
  endtask

  task automatic model_load();
    m_hblock = {m_fill[0], m_fill[1], m_fill[2], m_fill[3]};
    m_htype  = m_ftype;
    m_hvalid = 1'b1;
    m_fill.delete();
  endtask

  // One clock cycle: drive, let the edge happen, advance model, compare.
  task automatic step(input logic rst, input logic v, input logic [31:0] d,
                      input logic t, input logic c, input logic f);
    bit loaded;
    bit hfree;
    @(negedge clk);
    n_rst = rst; word_valid = v; word_data = d; word_type = t;
    consume = c; flush = f;
    @(posedge clk);
    if (!rst) begin
      m_fill.delete(); m_ftype = 1'b0; m_hvalid = 1'b0; m_htype = 1'b0;
      m_hblock = 128'd0; m_terr = 1'b0;
    end else if (f) begin
      m_fill.delete(); m_hvalid = 1'b0; m_terr = 1'b0;
    end else begin
      m_terr = 1'b0;
      loaded = 1'b0;
      hfree  = !m_hvalid || c;
      if (m_fill.size() == 4) begin
        if (hfree) begin model_load(); loaded = 1'b1; end
      end else if (v) begin
        if (m_fill.size() > 0 && t != m_ftype) begin
          m_fill.delete(); m_fill.push_back(d); m_ftype = t; m_terr = 1'b1;
        end else begin
          if (m_fill.size() == 0) m_ftype = t;
          m_fill.push_back(d);
          if (m_fill.size() == 4 && hfree) begin model_load(); loaded = 1'b1; end
        end
      end
      if (c && !loaded) m_hvalid = 1'b0;
    end
    #1;
    check_all();
  endtask

  task automatic send(input logic [31:0] d, input logic t, input logic c);
    step(1'b1, 1'b1, d, t, c, 1'b0);
  endtask

  task automatic idle(input logic c);
    step(1'b1, 1'b0, 32'd0, 1'b0, c, 1'b0);
  endtask

  initial begin
    logic [127:0] saved;
    logic         rt;
    logic         last_t;

    // Reset
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("reset_block_out", block_out, 128'd0);
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    chk("reset_word_ready", {127'd0, word_ready}, 128'd1);

    // Single key block
    send(32'h00010203, 1'b0, 1'b0);
    send(32'h04050607, 1'b0, 1'b0);
    send(32'h08090A0B, 1'b0, 1'b0);
    send(32'h0C0D0E0F, 1'b0, 1'b0);
    chk("single_block", block_out, 128'h000102030405060708090A0B0C0D0E0F);
    chk("single_recv", {127'd0, data_received}, 128'd1);
    chk("single_type", {127'd0, data_type}, 128'd0);
    idle(1'b1);

    // Backpressure: two data blocks, no consume
    for (int i = 0; i < 4; i++) send(32'hA000_0000 + 32'(i), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) send(32'hB000_0000 + 32'(i), 1'b1, 1'b0);
    chk("bp_ready_low", {127'd0, word_ready}, 128'd0);
    chk("bp_count4", {125'd0, fill_count}, 128'd4);
    chk("bp_block_a", block_out, 128'hA0000000A0000001A0000002A0000003);
    idle(1'b1);
    chk("bp_block_b", block_out, 128'hB0000000B0000001B0000002B0000003);
    idle(1'b0);
    chk("bp_ready_back", {127'd0, word_ready}, 128'd1);
    idle(1'b1);

    // Streaming: consume whenever a block is held
    for (int i = 0; i < 12; i++) send(32'hC000_0000 + 32'(i), 1'b1, m_hvalid);
    chk("stream_last", block_out, 128'hC0000008C0000009C000000AC000000B);
    idle(1'b1);

    // Type switch mid-block
    send(32'hD0D0D0D0, 1'b1, 1'b0);
    send(32'hD1D1D1D1, 1'b1, 1'b0);
    send(32'hE0E0E0E0, 1'b0, 1'b0);
    chk("tswitch_pulse", {127'd0, type_error}, 128'd1);
    send(32'hE1E1E1E1, 1'b0, 1'b0);
    chk("tswitch_single", {127'd0, type_error}, 128'd0);
    send(32'hE2E2E2E2, 1'b0, 1'b0);
    send(32'hE3E3E3E3, 1'b0, 1'b0);
    chk("tswitch_block", block_out, 128'hE0E0E0E0E1E1E1E1E2E2E2E2E3E3E3E3);
    chk("tswitch_type", {127'd0, data_type}, 128'd0);

    // Flush with a held block and two words filled
    saved = block_out;
    send(32'h11111111, 1'b1, 1'b0);
    send(32'h22222222, 1'b1, 1'b0);
    step(1'b1, 1'b1, 32'h33333333, 1'b1, 1'b0, 1'b1);
    chk("flush_block_kept", block_out, saved);
    chk("flush_count", {125'd0, fill_count}, 128'd0);

    // Same state, then reset
    for (int i = 0; i < 6; i++) send(32'h4400_0000 + 32'(i), 1'b1, 1'b0);
    step(1'b0, 1'b1, 32'h55555555, 1'b1, 1'b0, 1'b0);
    chk("rst_mid_block", block_out, 128'd0);

    // Spurious consume, then a normal block
    idle(1'b1);
    idle(1'b1);
    for (int i = 0; i < 4; i++) send(32'h6600_0000 + 32'(i), 1'b1, 1'b0);
    chk("spurious_block", block_out, 128'h66000000660000016600000266000003);

    // Randomized traffic
    last_t = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rt = (($urandom % 8) == 0) ? ~last_t : last_t;
      last_t = rt;
      step((($urandom % 200) != 0), (($urandom % 4) != 0), $urandom, rt,
           (($urandom % 3) == 0), (($urandom % 64) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
